fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Sequences instruction fetch: owns the PC, issues one request at a time to instruction memory,
//  holds the fetched word for decode while the hazard unit stalls, and applies branch/jump redirects.
//  Sits between the instruction memory and the decode stage, in front of the instruction register.
// PARAMETERS
//  ADDR_W    32   PC / memory address width
//  RESET_PC  0    PC loaded on reset
//  PC_STEP   4    PC increment per consumed instruction
// PORTS
//  Clk          in   1       clock, rising edge
//  Reset        in   1       asynchronous, active-low reset
//  ImemReq      out  1       one-cycle fetch request strobe
//  ImemAddr     out  ADDR_W  fetch address, valid while ImemReq=1
//  ImemValid    in   1       memory response strobe; one per request, latency >=1 cycle
//  ImemData     in   32      instruction word, valid with ImemValid
//  Stall        in   1       decode cannot accept; Instruction must be held
//  RedirectEn   in   1       branch/jump taken this cycle
//  RedirectPC   in   ADDR_W  target PC, sampled when RedirectEn=1
//  Instruction  out  32      fetched instruction (registered)
//  InstrPC      out  ADDR_W  address of Instruction
//  InstrValid   out  1       Instruction valid; consumed on a cycle with InstrValid=1 && Stall=0
// BEHAVIOUR
//  - Reset (Reset=0, async): state=IDLE, PC=RESET_PC, ImemReq=0, ImemAddr=RESET_PC,
//    Instruction=0, InstrPC=0, InstrValid=0, perf counters=0.
//  - All outputs registered. States: IDLE, REQ, WAIT, HOLD, DRAIN.
//  - IDLE: one cycle after reset release -> REQ.
//  - REQ: ImemReq=1 exactly one cycle, ImemAddr=PC -> WAIT.
//  - WAIT: on ImemValid: Instruction<=ImemData, InstrPC<=PC, InstrValid<=1, PC<=PC+PC_STEP -> HOLD.
//  - HOLD: InstrValid=1 and Instruction/InstrPC stable while Stall=1; Stall=0 consumes -> REQ,
//    InstrValid<=0 next cycle. Min spacing: REQ, WAIT(>=1), HOLD = 3 cycles per instruction.
//  - ImemValid outside WAIT/DRAIN is ignored.
//  - PC arithmetic modulo 2^ADDR_W (wrap at all-ones silently).
//  - Redirect (RedirectEn=1) has priority over every other event; PC<=RedirectPC, InstrValid<=0:
//    IDLE/REQ/HOLD -> REQ (REQ already strobed is orphaned: -> DRAIN instead, see below);
//    HOLD with Stall=0 and redirect: instruction counts as consumed, then redirect applies;
//    WAIT without ImemValid -> DRAIN; WAIT with ImemValid same cycle -> response discarded, -> REQ;
//    REQ (request issued this cycle) -> DRAIN; DRAIN -> stay DRAIN with new PC.
//  - DRAIN: wait for the one outstanding ImemValid, discard it (no output change) -> REQ.
//  - Stall outside HOLD has no effect; fetching continues up to HOLD.
//  - Reset mid-operation: state returns to IDLE immediately; memory must be reset in the same
//    domain so no stale response follows.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds outputs FetchCount (out, 32) = consumed instructions and
//    RedirectCount (out, 16) = accepted redirects; both saturate at all-ones, reset to 0.
//  FETCH_PERF_EN undefined: ports and counters absent; remaining behaviour identical.
// TESTING
//  - Reset low then high, memory latency 1, Stall=0 -> ImemAddr 0x0,0x4,0x8 every 3 cycles;
//    InstrPC matches; InstrValid one-cycle pulses.
//  - Stall=1 for 5 cycles in HOLD with Instruction=0x2002_0005 -> Instruction/InstrValid held
//    5 cycles, no ImemReq; Stall=0 -> next ImemAddr=PC+4.
//  - RedirectEn with RedirectPC=0x100 in WAIT, latency 3 -> stale response dropped,
//    InstrValid stays 0, next ImemAddr=0x100.
//  - RedirectEn coincident with ImemValid in WAIT -> response discarded, next ImemReq addr=RedirectPC.
//  - RESET_PC=32'hFFFF_FFFC -> second fetch ImemAddr=0x0 (wrap).
//  - Reset asserted in HOLD -> all outputs zero in same cycle; FETCH_PERF_EN: FetchCount=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC and issues one instruction fetch at a time.
// It holds the fetched word for decode while stalled and applies branch/jump redirects.
// Optional build macro FETCH_PERF_EN adds two saturating performance counters:
//   FetchCount    counts consumed instructions.
//   RedirectCount counts accepted redirects.
module fetch_sequencer #(
  parameter int unsigned           ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0,
  parameter logic [ADDR_W-1:0]     PC_STEP  = ADDR_W'(4)
) (
  input  logic              Clk,
  input  logic              Reset,
  output logic              ImemReq,
  output logic [ADDR_W-1:0] ImemAddr,
  input  logic              ImemValid,
  input  logic [31:0]       ImemData,
  input  logic              Stall,
  input  logic              RedirectEn,
  input  logic [ADDR_W-1:0] RedirectPC,
  output logic [31:0]       Instruction,
  output logic [ADDR_W-1:0] InstrPC,
  output logic              InstrValid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       FetchCount,
  output logic [15:0]       RedirectCount
`endif
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              imemReq_q, imemReq_d;
  logic [ADDR_W-1:0] imemAddr_q, imemAddr_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] instrPc_q, instrPc_d;
  logic              instrValid_q, instrValid_d;

  // Next-state logic: the normal fetch walk first, then a redirect overrides it.
  // Every entry into REQ also loads the request strobe and address for that cycle.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    imemReq_d    = 1'b0;
    imemAddr_d   = imemAddr_q;
    instr_d      = instr_q;
    instrPc_d    = instrPc_q;
    instrValid_d = instrValid_q;

    case (state_q)
      IDLE:  state_d = REQ;
      REQ:   state_d = WAIT;
      WAIT: begin
        if (ImemValid) begin
          instr_d      = ImemData;
          instrPc_d    = pc_q;
          instrValid_d = 1'b1;
          pc_d         = pc_q + PC_STEP;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (!Stall) begin
          instrValid_d = 1'b0;
          state_d      = REQ;
        end
      end
      DRAIN: begin
        if (ImemValid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    if (RedirectEn) begin
      pc_d         = RedirectPC;
      instr_d      = instr_q;
      instrPc_d    = instrPc_q;
      instrValid_d = 1'b0;
      case (state_q)
        REQ:     state_d = DRAIN;
        WAIT:    state_d = ImemValid ? REQ : DRAIN;
        DRAIN:   state_d = ImemValid ? REQ : DRAIN;
        default: state_d = REQ;
      endcase
    end

    if (state_d == REQ) begin
      imemReq_d  = 1'b1;
      imemAddr_d = pc_d;
    end
  end

  // State, PC and all visible outputs are registered here.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      imemReq_q    <= 1'b0;
      imemAddr_q   <= RESET_PC;
      instr_q      <= '0;
      instrPc_q    <= '0;
      instrValid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      imemReq_q    <= imemReq_d;
      imemAddr_q   <= imemAddr_d;
      instr_q      <= instr_d;
      instrPc_q    <= instrPc_d;
      instrValid_q <= instrValid_d;
    end
  end

  assign ImemReq     = imemReq_q;
  assign ImemAddr    = imemAddr_q;
  assign Instruction = instr_q;
  assign InstrPC     = instrPc_q;
  assign InstrValid  = instrValid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetchCount_q;
  logic [15:0] redirectCount_q;
  logic        consume;

  assign consume = (state_q == HOLD) && !Stall;

  // Saturating counters: instructions taken by decode, and redirects accepted.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fetchCount_q    <= '0;
      redirectCount_q <= '0;
    end else begin
      if (consume && (fetchCount_q != '1)) fetchCount_q <= fetchCount_q + 32'd1;
      if (RedirectEn && (redirectCount_q != '1)) redirectCount_q <= redirectCount_q + 16'd1;
    end
  end

  assign FetchCount    = fetchCount_q;
  assign RedirectCount = redirectCount_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed test of fetch_sequencer with a variable-latency memory model.
// A second instance, with RESET_PC near the top of the address space, checks PC wrap-around.
module tb_fetch_sequencer;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic        ImemReq;
   logic [31:0] ImemAddr;
   logic        ImemValid = 1'b0;
   logic [31:0] ImemData = 32'd0;
   logic        Stall = 1'b0;
   logic        RedirectEn = 1'b0;
   logic [31:0] RedirectPC = 32'd0;
   logic [31:0] Instruction;
   logic [31:0] InstrPC;
   logic        InstrValid;
`ifdef FETCH_PERF_EN
   logic [31:0] FetchCount;
   logic [15:0] RedirectCount;
`endif

   logic        imemReq2;
   logic [31:0] imemAddr2;
   logic        imemValid2 = 1'b0;
   logic [31:0] imemData2 = 32'd0;
   logic [31:0] instruction2;
   logic [31:0] instrPc2;
   logic        instrValid2;
`ifdef FETCH_PERF_EN
   logic [31:0] fetchCount2;
   logic [15:0] redirectCount2;
`endif

   int          checkCount = 0;
   int          errorCount = 0;
   int          memLat = 1;
   int          pending = 0;
   logic [31:0] memAddr = 32'd0;
   int          pending2 = 0;
   logic [31:0] memAddr2 = 32'd0;
   logic [31:0] reqLog2 [2];
   int          reqLogCount2 = 0;
   logic [31:0] firstInstr2 = 32'd0;
   logic [31:0] firstPc2 = 32'd0;
   bit          firstSeen2 = 1'b0;

   fetch_sequencer dut (
      .Clk(Clk), .Reset(Reset), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
      .ImemValid(ImemValid), .ImemData(ImemData), .Stall(Stall),
      .RedirectEn(RedirectEn), .RedirectPC(RedirectPC), .Instruction(Instruction),
      .InstrPC(InstrPC), .InstrValid(InstrValid)
`ifdef FETCH_PERF_EN
      , .FetchCount(FetchCount), .RedirectCount(RedirectCount)
`endif
   );

   fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
      .Clk(Clk), .Reset(Reset), .ImemReq(imemReq2), .ImemAddr(imemAddr2),
      .ImemValid(imemValid2), .ImemData(imemData2), .Stall(1'b0),
      .RedirectEn(1'b0), .RedirectPC(32'd0), .Instruction(instruction2),
      .InstrPC(instrPc2), .InstrValid(instrValid2)
`ifdef FETCH_PERF_EN
      , .FetchCount(fetchCount2), .RedirectCount(redirectCount2)
`endif
   );

   // Free-running clock, 10 time units per cycle.
   always #5 Clk = ~Clk;

   // Memory contents: each word is 0x2002_0000 plus its word index plus one.
   // For example, address 0x10 holds 0x2002_0005.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return 32'h2002_0000 + (a >> 2) + 32'd1;
   endfunction

   // Memory models. A request is seen on the falling edge of its cycle.
   // The response is driven so that the DUT samples it memLat cycles later.
   always @(negedge Clk) begin
      if (!Reset) begin
         pending = 0;
         ImemValid = 1'b0;
         pending2 = 0;
         imemValid2 = 1'b0;
      end else begin
         ImemValid = 1'b0;
         if (pending > 0) begin
            pending = pending - 1;
            if (pending == 0) begin
               ImemValid = 1'b1;
               ImemData = memWord(memAddr);
            end
         end
         if (ImemReq) begin
            pending = memLat;
            memAddr = ImemAddr;
         end
         imemValid2 = 1'b0;
         if (pending2 > 0) begin
            pending2 = pending2 - 1;
            if (pending2 == 0) begin
               imemValid2 = 1'b1;
               imemData2 = memWord(memAddr2);
            end
         end
         if (imemReq2) begin
            pending2 = 1;
            memAddr2 = imemAddr2;
            if (reqLogCount2 < 2) begin
               reqLog2[reqLogCount2] = imemAddr2;
               reqLogCount2 = reqLogCount2 + 1;
            end
         end
         if (instrValid2 && !firstSeen2) begin
            firstSeen2 = 1'b1;
            firstInstr2 = instruction2;
            firstPc2 = instrPc2;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) else begin
         errorCount++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic r, input logic [31:0] pc);
      Stall = s;
      RedirectEn = r;
      RedirectPC = pc;
      @(negedge Clk);
   endtask

   task automatic waitInstr(input string tag);
      int n = 0;
      while (InstrValid !== 1'b1 && n < 50) begin
         applyStimulus(1'b0, 1'b0, 32'd0);
         n++;
      end
      checkOutput({tag, " ready"}, 32'(InstrValid), 32'd1);
   endtask

   // Directed sequence: sequential fetch, stall hold, redirects, wrap-around, reset in HOLD.
   initial begin
      @(negedge Clk);
      @(negedge Clk);
      checkOutput("rst ImemReq", 32'(ImemReq), 32'd0);
      checkOutput("rst ImemAddr", ImemAddr, 32'h0);
      checkOutput("rst Instruction", Instruction, 32'h0);
      checkOutput("rst InstrValid", 32'(InstrValid), 32'd0);
      checkOutput("rst wrap ImemAddr", imemAddr2, 32'hFFFF_FFFC);
      Reset = 1'b1;

      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b0, 1'b0, 32'd0);
         checkOutput("seq ImemReq", 32'(ImemReq), 32'd1);
         checkOutput("seq ImemAddr", ImemAddr, 32'(4 * k));
         checkOutput("seq pulse end", 32'(InstrValid), 32'd0);
         applyStimulus(1'b0, 1'b0, 32'd0);
         checkOutput("seq wait ImemReq", 32'(ImemReq), 32'd0);
         applyStimulus(1'b0, 1'b0, 32'd0);
         checkOutput("seq InstrValid", 32'(InstrValid), 32'd1);
         checkOutput("seq Instruction", Instruction, 32'h2002_0001 + 32'(k));
         checkOutput("seq InstrPC", InstrPC, 32'(4 * k));
      end

      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b0, 32'd0);
         checkOutput("stall InstrValid", 32'(InstrValid), 32'd1);
         checkOutput("stall Instruction", Instruction, 32'h2002_0005);
         checkOutput("stall InstrPC", InstrPC, 32'h10);
         checkOutput("stall ImemReq", 32'(ImemReq), 32'd0);
      end
      applyStimulus(1'b0, 1'b0, 32'd0);
      checkOutput("unstall ImemReq", 32'(ImemReq), 32'd1);
      checkOutput("unstall ImemAddr", ImemAddr, 32'h14);

      checkOutput("wrap req count", 32'(reqLogCount2), 32'd2);
      checkOutput("wrap first addr", reqLog2[0], 32'hFFFF_FFFC);
      checkOutput("wrap second addr", reqLog2[1], 32'h0);
      checkOutput("wrap InstrPC", firstPc2, 32'hFFFF_FFFC);
      checkOutput("wrap Instruction", firstInstr2, 32'h6002_0000);

      waitInstr("fetch 0x14");
      checkOutput("fetch 0x14 InstrPC", InstrPC, 32'h14);
      memLat = 3;
      applyStimulus(1'b0, 1'b0, 32'd0);
      checkOutput("lat3 ImemAddr", ImemAddr, 32'h18);
      applyStimulus(1'b0, 1'b0, 32'd0);
      checkOutput("lat3 wait ImemReq", 32'(ImemReq), 32'd0);
      applyStimulus(1'b0, 1'b1, 32'h100);
      checkOutput("drain InstrValid", 32'(InstrValid), 32'd0);
      checkOutput("drain ImemReq", 32'(ImemReq), 32'd0);
      applyStimulus(1'b0, 1'b0, 32'd0);
      checkOutput("drain2 ImemReq", 32'(ImemReq), 32'd0);
      checkOutput("drain2 InstrValid", 32'(InstrValid), 32'd0);
      applyStimulus(1'b0, 1'b0, 32'd0);
      checkOutput("redir ImemReq", 32'(ImemReq), 32'd1);
      checkOutput("redir ImemAddr", ImemAddr, 32'h100);
      checkOutput("redir InstrValid", 32'(InstrValid), 32'd0);
      waitInstr("fetch 0x100");
      checkOutput("fetch 0x100 Instruction", Instruction, 32'h2002_0041);
      checkOutput("fetch 0x100 InstrPC", InstrPC, 32'h100);

      memLat = 1;
      applyStimulus(1'b0, 1'b0, 32'd0);
      checkOutput("coinc req ImemAddr", ImemAddr, 32'h104);
      applyStimulus(1'b0, 1'b0, 32'd0);
      applyStimulus(1'b0, 1'b1, 32'h200);
      checkOutput("coinc ImemReq", 32'(ImemReq), 32'd1);
      checkOutput("coinc ImemAddr", ImemAddr, 32'h200);
      checkOutput("coinc InstrValid", 32'(InstrValid), 32'd0);
      checkOutput("coinc Instruction kept", Instruction, 32'h2002_0041);
      waitInstr("fetch 0x200");
      checkOutput("fetch 0x200 Instruction", Instruction, 32'h2002_0081);
      checkOutput("fetch 0x200 InstrPC", InstrPC, 32'h200);

      Reset = 1'b0;
      #1;
      checkOutput("hold rst ImemReq", 32'(ImemReq), 32'd0);
      checkOutput("hold rst ImemAddr", ImemAddr, 32'h0);
      checkOutput("hold rst Instruction", Instruction, 32'h0);
      checkOutput("hold rst InstrPC", InstrPC, 32'h0);
      checkOutput("hold rst InstrValid", 32'(InstrValid), 32'd0);
`ifdef FETCH_PERF_EN
      checkOutput("hold rst FetchCount", FetchCount, 32'd0);
      checkOutput("hold rst RedirectCount", 32'(RedirectCount), 32'd0);
`endif
      @(negedge Clk);
      Reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'd0);
      checkOutput("restart ImemReq", 32'(ImemReq), 32'd1);
      checkOutput("restart ImemAddr", ImemAddr, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
